// File: rtl/fpu_ext_to_fp64_if.sv
// Operand/result handshake bundle between the x87 register stack and the
// extended-to-binary64 converter.
interface fpu_ext_to_fp64_if;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] in_data;
   logic [1:0]  rc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  out_flags;

   modport master (
      output in_valid,
      output in_data,
      output rc,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_flags
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  rc,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_flags
   );
endinterface

// File: rtl/fpu_ext_to_fp64.sv
// Narrows an x87 80-bit extended value to binary64: iterative normalization,
// RC-controlled rounding, x87 flags, and flush of sub-normal-range results to zero.
module fpu_ext_to_fp64 (
   input logic               clk,
   input logic               rst_n,
   fpu_ext_to_fp64_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

   localparam logic [3:0]  FlagNone = 4'b0000;
   localparam logic [3:0]  FlagIe   = 4'b1000;
   localparam logic [3:0]  FlagOePe = 4'b0101;
   localparam logic [3:0]  FlagUePe = 4'b0011;
   localparam logic [3:0]  FlagPe   = 4'b0001;
   localparam logic [62:0] MagInf   = 63'h7FF0_0000_0000_0000;
   localparam logic [62:0] MagMax   = 63'h7FEF_FFFF_FFFF_FFFF;
   localparam logic [63:0] QnanDflt = 64'hFFF8_0000_0000_0000;
   localparam logic signed [16:0] ExpBias = 17'sd15360;
   localparam logic signed [16:0] ExpOvf  = 17'sd2047;

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [16:0] exp_q, exp_d;
   logic [63:0]        mant_q, mant_d;
   logic [1:0]         rc_q, rc_d;
   logic               special_q, special_d;
   logic [63:0]        data_q, data_d;
   logic [3:0]         flags_q, flags_d;

   logic               in_sign;
   logic [14:0]        in_exp;
   logic [63:0]        in_mant;

   logic signed [16:0] e_pre, e_post;
   logic [51:0]        frac;
   logic               guard, sticky, inc;
   logic [52:0]        frac_sum;
   logic [62:0]        ovf_mag;

   assign in_sign = bus.in_data[79];
   assign in_exp  = bus.in_data[78:64];
   assign in_mant = bus.in_data[63:0];

   // Rounding datapath, evaluated from the normalized operand held in ROUND.
   assign e_pre    = exp_q - ExpBias;
   assign frac     = mant_q[62:11];
   assign guard    = mant_q[10];
   assign sticky   = |mant_q[9:0];
   assign frac_sum = {1'b0, frac} + {52'd0, inc};
   assign e_post   = e_pre + $signed({16'd0, frac_sum[52]});

   always_comb begin
      inc = 1'b0;
      case (rc_q)
         2'b00:   inc = guard & (sticky | frac[0]);
         2'b01:   inc = (guard | sticky) & sign_q;
         2'b10:   inc = (guard | sticky) & ~sign_q;
         default: inc = 1'b0;
      endcase
   end

   always_comb begin
      ovf_mag = MagMax;
      case (rc_q)
         2'b00:   ovf_mag = MagInf;
         2'b01:   ovf_mag = sign_q ? MagInf : MagMax;
         2'b10:   ovf_mag = sign_q ? MagMax : MagInf;
         default: ovf_mag = MagMax;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      rc_d      = rc_q;
      special_d = special_q;
      data_d    = data_q;
      flags_d   = flags_q;

      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               sign_d    = in_sign;
               exp_d     = $signed({2'b00, in_exp});
               mant_d    = in_mant;
               rc_d      = bus.rc;
               special_d = 1'b1;
               state_d   = StNorm;
               // Specials resolve here but still spend one cycle in NORM.
               if (in_exp == 15'h0000) begin
                  data_d  = {in_sign, 63'd0};
                  flags_d = (in_mant != 64'd0) ? FlagUePe : FlagNone;
               end else if (in_exp == 15'h7FFF) begin
                  if (!in_mant[63]) begin
                     data_d  = QnanDflt;
                     flags_d = FlagIe;
                  end else if (in_mant[62:0] == 63'd0) begin
                     data_d  = {in_sign, MagInf};
                     flags_d = FlagNone;
                  end else begin
                     data_d  = {in_sign, 11'h7FF, 1'b1, in_mant[61:11]};
                     flags_d = in_mant[62] ? FlagNone : FlagIe;
                  end
               end else begin
                  special_d = 1'b0;
               end
            end
         end

         StNorm: begin
            if (special_q) begin
               state_d = StDone;
            end else if (mant_q == 64'd0) begin
               data_d  = {sign_q, 63'd0};
               flags_d = FlagNone;
               state_d = StDone;
            end else if (mant_q[63]) begin
               state_d = StRound;
            end else begin
               mant_d = {mant_q[62:0], 1'b0};
               exp_d  = exp_q - 17'sd1;
            end
         end

         StRound: begin
            if (e_pre <= 17'sd0) begin
               data_d  = {sign_q, 63'd0};
               flags_d = FlagUePe;
            end else if (e_post >= ExpOvf) begin
               data_d  = {sign_q, ovf_mag};
               flags_d = FlagOePe;
            end else begin
               data_d  = {sign_q, e_post[10:0], frac_sum[51:0]};
               flags_d = (guard | sticky) ? FlagPe : FlagNone;
            end
            state_d = StDone;
         end

         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         rc_q      <= '0;
         special_q <= 1'b0;
         data_q    <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         rc_q      <= rc_d;
         special_q <= special_d;
         data_q    <= data_d;
         flags_q   <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_data  = data_q;
   assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_fpu_ext_to_fp64.sv
// Bench for fpu_ext_to_fp64: directed vector table, randomized operands against a
// value-level reference model, backpressure and mid-conversion reset sequences.
module tb_fpu_ext_to_fp64;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   fpu_ext_to_fp64_if bus ();

   fpu_ext_to_fp64 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] x;
      logic [1:0]  rc;
      logic [63:0] d;
      logic [3:0]  f;
      int          lat;
      string       name;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference conversion from the value rules: count leading zeros, then round
   // the 53-bit significand by examining the discarded 11-bit remainder.
   task automatic model(input logic [79:0] x, input logic [1:0] r,
                        output logic [63:0] d, output logic [3:0] fl, output int lat);
      logic        s;
      logic [14:0] ex;
      logic [63:0] m, mn;
      logic [53:0] keep;
      logic [10:0] rem;
      logic [62:0] mag;
      logic        up;
      int          lz, e;
      s  = x[79];
      ex = x[78:64];
      m  = x[63:0];
      lat = 1;
      fl  = 4'h0;
      d   = {s, 63'd0};
      if (ex == 15'h0) begin
         fl = (m != 0) ? 4'h3 : 4'h0;
      end else if (ex == 15'h7FFF) begin
         if (!m[63]) begin
            d = 64'hFFF8_0000_0000_0000; fl = 4'h8;
         end else if (m[62:0] == 0) begin
            d = {s, 63'h7FF0_0000_0000_0000};
         end else begin
            d = {s, 11'h7FF, 1'b1, m[61:11]}; fl = m[62] ? 4'h0 : 4'h8;
         end
      end else if (m != 0) begin
         lz = 0;
         for (int i = 0; i < 64; i++) if (m[i]) lz = 63 - i;
         lat = 2 + lz;
         mn  = m << lz;
         e   = int'(ex) - lz - 15360;
         if (e <= 0) begin
            fl = 4'h3;
         end else begin
            keep = {1'b0, mn[63:11]};
            rem  = mn[10:0];
            case (r)
               2'b00:   up = (rem > 11'd1024) || (rem == 11'd1024 && keep[0]);
               2'b01:   up = s && (rem != 0);
               2'b10:   up = !s && (rem != 0);
               default: up = 1'b0;
            endcase
            keep = keep + 54'(up);
            if (keep[53]) begin
               keep = keep >> 1;
               e = e + 1;
            end
            if (e >= 2047) begin
               case (r)
                  2'b00:   mag = 63'h7FF0_0000_0000_0000;
                  2'b01:   mag = s ? 63'h7FF0_0000_0000_0000 : 63'h7FEF_FFFF_FFFF_FFFF;
                  2'b10:   mag = s ? 63'h7FEF_FFFF_FFFF_FFFF : 63'h7FF0_0000_0000_0000;
                  default: mag = 63'h7FEF_FFFF_FFFF_FFFF;
               endcase
               d  = {s, mag};
               fl = 4'h5;
            end else begin
               d  = {s, 11'(e), keep[51:0]};
               fl = (rem != 0) ? 4'h1 : 4'h0;
            end
         end
      end
   endtask

   // Offer one operand, measure latency, check the result and complete the handshake.
   task automatic run_vec(input logic [79:0] x, input logic [1:0] r, input logic [63:0] ed,
                          input logic [3:0] ef, input int elat, input string nm);
      int lat;
      @(negedge clk);
      chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      bus.rc       = r;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom(), $urandom(), 16'($urandom())};
      bus.rc       = 2'($urandom());
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = c;
            break;
         end
      end
      chk({nm, " latency"}, 64'(lat), 64'(elat));
      chk({nm, " data"}, bus.out_data, ed);
      chk({nm, " flags"}, 64'(bus.out_flags), 64'(ef));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({nm, " out_valid after handshake"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      logic [79:0] x;
      logic [63:0] ed, held;
      logic [3:0]  ef;
      logic [1:0]  r;
      logic [63:0] m;
      logic [14:0] ex;
      int          elat, sel;
      logic        saw;

      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.rc        = 2'b00;
      bus.out_ready = 1'b0;

      tbl[0]  = '{80'h3FFF_8000_0000_0000_0000, 2'b00, 64'h3FF0_0000_0000_0000, 4'h0, 2, "one"};
      tbl[1]  = '{80'h3FFF_4000_0000_0000_0000, 2'b00, 64'h3FE0_0000_0000_0000, 4'h0, 3, "unnorm1"};
      tbl[2]  = '{80'h3FFF_0000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000, 4'h0, 1, "mant0"};
      tbl[3]  = '{80'h3FFF_8000_0000_0000_0400, 2'b00, 64'h3FF0_0000_0000_0000, 4'h1, 2, "tie_rne"};
      tbl[4]  = '{80'h3FFF_8000_0000_0000_0400, 2'b10, 64'h3FF0_0000_0000_0001, 4'h1, 2, "tie_up"};
      tbl[5]  = '{80'h3FFF_8000_0000_0000_0400, 2'b01, 64'h3FF0_0000_0000_0000, 4'h1, 2, "tie_dn"};
      tbl[6]  = '{80'h43FF_8000_0000_0000_0000, 2'b00, 64'h7FF0_0000_0000_0000, 4'h5, 2, "ovf_rne"};
      tbl[7]  = '{80'h43FF_8000_0000_0000_0000, 2'b11, 64'h7FEF_FFFF_FFFF_FFFF, 4'h5, 2, "ovf_trc"};
      tbl[8]  = '{80'hC3FF_8000_0000_0000_0000, 2'b10, 64'hFFEF_FFFF_FFFF_FFFF, 4'h5, 2, "ovf_neg_up"};
      tbl[9]  = '{80'h7FFF_A000_0000_0000_0000, 2'b00, 64'h7FFC_0000_0000_0000, 4'h8, 1, "snan"};
      tbl[10] = '{80'h7FFF_0000_0000_0000_0001, 2'b00, 64'hFFF8_0000_0000_0000, 4'h8, 1, "pseudo_nan"};
      tbl[11] = '{80'h0000_0000_0000_0000_0001, 2'b00, 64'h0000_0000_0000_0000, 4'h3, 1, "denorm80"};
      tbl[12] = '{80'h7FFF_8000_0000_0000_0000, 2'b00, 64'h7FF0_0000_0000_0000, 4'h0, 1, "inf"};
      tbl[13] = '{80'hFFFF_C000_0000_0000_0000, 2'b00, 64'hFFF8_0000_0000_0000, 4'h0, 1, "qnan_neg"};
      tbl[14] = '{80'h3C00_8000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000, 4'h3, 2, "e_zero"};
      tbl[15] = '{80'h3C01_8000_0000_0000_0000, 2'b00, 64'h0010_0000_0000_0000, 4'h0, 2, "min_norm"};
      tbl[16] = '{80'h3FFF_FFFF_FFFF_FFFF_FFFF, 2'b00, 64'h4000_0000_0000_0000, 4'h1, 2, "carry"};
      tbl[17] = '{80'h8000_0000_0000_0000_0000, 2'b00, 64'h8000_0000_0000_0000, 4'h0, 1, "neg_zero"};

      repeat (3) @(negedge clk);
      chk("reset in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset out_data", bus.out_data, 64'd0);
      chk("reset out_flags", 64'(bus.out_flags), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         run_vec(tbl[i].x, tbl[i].rc, tbl[i].d, tbl[i].f, tbl[i].lat, tbl[i].name);
      end

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0:       ex = 15'h0;
            1:       ex = 15'h7FFF;
            2, 3, 4: ex = 15'($urandom_range(15300, 15500));
            5:       ex = 15'($urandom_range(17340, 17420));
            default: ex = 15'($urandom_range(15360, 17400));
         endcase
         m = {$urandom(), $urandom()};
         if ($urandom_range(0, 1) == 0) m[63] = 1'b1;
         else m = m >> $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) m[10:0] = ($urandom_range(0, 1) == 0) ? 11'h400 : 11'h7FF;
         x = {1'($urandom()), ex, m};
         r = 2'($urandom());
         model(x, r, ed, ef, elat);
         run_vec(x, r, ed, ef, elat, $sformatf("rand%0d", i));
      end

      // Backpressure: result held, no accept while in_valid stays high.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 80'h3FFF_8000_0000_0000_0000;
      bus.rc       = 2'b00;
      @(posedge clk);
      #1;
      bus.in_data = 80'h4000_C000_0000_0000_0000;
      saw = 1'b0;
      for (int c = 0; c < 10 && !saw; c++) begin
         @(posedge clk);
         #1;
         saw = bus.out_valid;
      end
      chk("bp first out_valid", 64'(saw), 64'd1);
      held = bus.out_data;
      chk("bp data", held, 64'h3FF0_0000_0000_0000);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp stable data", bus.out_data, held);
         chk("bp in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid || !bus.in_ready) saw = 1'b1;
      end
      chk("bp no second accept", 64'(saw), 64'd0);

      // Reset while normalizing a 63-shift unnormal.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 80'h4000_0000_0000_0000_0001;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst out_data", bus.out_data, 64'd0);
      chk("rst out_flags", 64'(bus.out_flags), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) saw = 1'b1;
      end
      chk("rst no result", 64'(saw), 64'd0);

      run_vec(tbl[0].x, tbl[0].rc, tbl[0].d, tbl[0].f, tbl[0].lat, "post_rst_one");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
